// File: rtl/op_encoder_pkg.sv
// Shared constants, FSM state type and opcode-to-line helper for op_encoder.
// Pure declarations: no latency, no flow control.
// Backpressure: not applicable.
package op_encoder_pkg;

    localparam int N_REQ  = 16;
    localparam int CODE_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [N_REQ-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/op_encoder_if.sv
// Opcode handshake bus between op_encoder (master) and the ALU control path (slave).
// Latency: wires only.
// Backpressure: op_ready from the slave stalls the master's offer.
interface op_encoder_if;
    import op_encoder_pkg::*;

    logic [CODE_W-1:0] op_code;
    logic              op_valid;
    logic              op_ready;

    modport master (
        output op_code,
        output op_valid,
        input  op_ready
    );

    modport slave (
        input  op_code,
        input  op_valid,
        output op_ready
    );

endinterface

// File: rtl/op_encoder_prio_enc16.sv
// Combinational 16-bit priority encoder; search starts at index 'start' and wraps upward.
// Latency: zero (pure combinational).
// Backpressure: not applicable.
module prio_enc16
    import op_encoder_pkg::*;
(
    input  logic [N_REQ-1:0]  vec,
    input  logic [CODE_W-1:0] start,
    output logic [CODE_W-1:0] code,
    output logic              found
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;

    always_comb begin
        dbl   = {vec, vec};
        // rot[j] holds vec[(j + start) mod 16], so the lowest set bit of rot is the winner
        rot   = N_REQ'(dbl >> start);
        code  = '0;
        found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                code  = CODE_W'(i) + start;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/op_encoder.sv
// Collects pulsed requests into a pending vector, issues one opcode per handshake.
// Latency: req to op_valid is one cycle; back-to-back issue while op_ready stays high.
// Backpressure: op_ready low holds op_code/op_valid stable. Define OP_ENCODER_RR_EN for round-robin.
module op_encoder
    import op_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             clr,
    op_encoder_if.master     bus,
    output logic [N_REQ-1:0] pending,
    output logic             overflow
);

    state_t            state, state_nx;
    logic [CODE_W-1:0] code_q, code_nx;
    logic              valid_q, valid_nx;

    logic              hs;
    logic [N_REQ-1:0]  served;
    logic [N_REQ-1:0]  pend_nx;
    logic [N_REQ-1:0]  avail;
    logic [CODE_W-1:0] start;
    logic [CODE_W-1:0] sel_code;
    logic              sel_found;

    assign hs      = valid_q & bus.op_ready;
    assign served  = hs ? onehot(code_q) : '0;
    assign pend_nx = (pending & ~served) | req;
    // A line re-armed in its own serve cycle waits one cycle before it can win again
    assign avail   = pend_nx & ~served;

`ifdef OP_ENCODER_RR_EN
    logic [CODE_W-1:0] rr_ptr;

    assign start = rr_ptr + CODE_W'(1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rr_ptr <= CODE_W'(N_REQ - 1);
        end else if (hs) begin
            rr_ptr <= code_q;
        end
    end
`else
    assign start = '0;
`endif

    prio_enc16 u_prio (
        .vec   (avail),
        .start (start),
        .code  (sel_code),
        .found (sel_found)
    );

    always_comb begin
        state_nx = state;
        code_nx  = code_q;
        valid_nx = valid_q;
        case (state)
            IDLE: begin
                valid_nx = 1'b0;
                if (sel_found) begin
                    code_nx  = sel_code;
                    valid_nx = 1'b1;
                    state_nx = OFFER;
                end
            end
            OFFER: begin
                if (hs) begin
                    if (sel_found) begin
                        code_nx = sel_code;
                    end else begin
                        valid_nx = 1'b0;
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                valid_nx = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state    <= IDLE;
            code_q   <= '0;
            valid_q  <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state   <= state_nx;
            code_q  <= code_nx;
            valid_q <= valid_nx;
            pending <= pend_nx;
            if (|(req & pending & ~served)) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.op_code  = code_q;
    assign bus.op_valid = valid_q;

endmodule

// File: tb/tb_op_encoder.sv
// Directed-vector bench for op_encoder with hand-computed expectations.
module tb_op_encoder;
    import op_encoder_pkg::*;

    logic             clk;
    logic             rst;
    logic             clr;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] pending;
    logic             overflow;

    int n_checks;
    int n_fail;

    op_encoder_if bus ();

    op_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .clr      (clr),
        .bus      (bus.master),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        clr          = 1'b0;
        req          = '0;
        bus.op_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_valid", 32'(bus.op_valid), 32'd0);
        chk("rst_code", 32'(bus.op_code), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        for (int i = 0; i < 5; i++) begin
            step();
            chk("quiet_valid", 32'(bus.op_valid), 32'd0);
            chk("quiet_pending", 32'(pending), 32'd0);
            chk("quiet_overflow", 32'(overflow), 32'd0);
        end

        // Two requests in one pulse: lower index first, then the other
        bus.op_ready = 1'b1;
        req = 16'h0024;
        step();
        req = '0;
        chk("pair_valid0", 32'(bus.op_valid), 32'd1);
        chk("pair_code0", 32'(bus.op_code), 32'd2);
        step();
        chk("pair_valid1", 32'(bus.op_valid), 32'd1);
        chk("pair_code1", 32'(bus.op_code), 32'd5);
        step();
        chk("pair_done", 32'(bus.op_valid), 32'd0);
        chk("pair_pending", 32'(pending), 32'd0);
        chk("pair_overflow", 32'(overflow), 32'd0);

        // Stalled offer, duplicate request raises sticky overflow
        bus.op_ready = 1'b0;
        req = 16'h0001;
        step();
        chk("stall_code", 32'(bus.op_code), 32'd0);
        chk("stall_valid", 32'(bus.op_valid), 32'd1);
        step();
        req = '0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_code", 32'(bus.op_code), 32'd0);
        chk("ovf_valid", 32'(bus.op_valid), 32'd1);
        step();
        chk("hold_code", 32'(bus.op_code), 32'd0);
        chk("hold_valid", 32'(bus.op_valid), 32'd1);
        bus.op_ready = 1'b1;
        step();
        chk("single_valid", 32'(bus.op_valid), 32'd0);
        chk("single_pending", 32'(pending), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        step();
        chk("single_idle", 32'(bus.op_valid), 32'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Full burst: 16 codes back-to-back, then idle
        req = 16'hFFFF;
        step();
        req = '0;
        for (int k = 0; k < N_REQ; k++) begin
            chk("burst_valid", 32'(bus.op_valid), 32'd1);
            chk("burst_code", 32'(bus.op_code), 32'(k));
            step();
        end
        chk("burst_end", 32'(bus.op_valid), 32'd0);
        chk("burst_pending", 32'(pending), 32'd0);

        // clr during an accepted offer drops it and all pending work
        bus.op_ready = 1'b0;
        req = 16'h0050;
        step();
        chk("pre_clr_code", 32'(bus.op_code), 32'd4);
        req = 16'h0010;
        step();
        req = '0;
        chk("pre_clr_ovf", 32'(overflow), 32'd1);
        bus.op_ready = 1'b1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_valid", 32'(bus.op_valid), 32'd0);
        chk("clr_pending", 32'(pending), 32'd0);
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_code", 32'(bus.op_code), 32'd0);
        step();
        chk("clr_stay_idle", 32'(bus.op_valid), 32'd0);
        chk("clr_stay_pend", 32'(pending), 32'd0);

        // Re-request of the line being served re-arms it without overflow
        bus.op_ready = 1'b0;
        req = 16'h0008;
        step();
        chk("rearm_code", 32'(bus.op_code), 32'd3);
        bus.op_ready = 1'b1;
        step();
        req = '0;
        chk("rearm_pending", 32'(pending), 32'h0008);
        chk("rearm_overflow", 32'(overflow), 32'd0);
        chk("rearm_gap", 32'(bus.op_valid), 32'd0);
        step();
        chk("reissue_valid", 32'(bus.op_valid), 32'd1);
        chk("reissue_code", 32'(bus.op_code), 32'd3);
        step();
        chk("reissue_done", 32'(bus.op_valid), 32'd0);
        chk("reissue_pend", 32'(pending), 32'd0);
        chk("reissue_ovf", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/op_encoder.md
# op_encoder

Sequential 16-to-4 request encoder: the inverse of the 4-to-16 function-select decoder in the ALU datapath. It collects pulsed one-hot/multi-hot function requests into a pending register, then issues them one at a time as a 4-bit opcode over a valid/ready handshake to the ALU control path. Arbitration is fixed-priority or round-robin, selected at compile time.

## Interface
- N_REQ, 16, number of request lines; fixed at 16 in this design.
- CODE_W, 4, opcode width; must equal log2(N_REQ).

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  N_REQ  request pulses; bit i requests opcode i; any number of bits may be high
- clr  input  1  synchronous flush of all pending work
- op_code  output  CODE_W  opcode offered to the ALU; registered
- op_valid  output  1  op_code is valid; registered
- op_ready  input  1  consumer accepts op_code this cycle
- pending  output  N_REQ  registered pending-request vector
- overflow  output  1  sticky: a request was merged into an already-pending line

## Operation
- Reset (rst=1 at an edge): pending=0, op_valid=0, op_code=0, overflow=0, state=IDLE, RR pointer=15.
- clr=1 at an edge: identical effect to rst. rst has precedence over clr; clr has precedence over everything else. An in-flight offer is dropped, even if op_ready=1 that cycle.
- served = onehot(op_code) when op_valid && op_ready, else 0.
- pend_nx = (pending & ~served) | req. pending <= pend_nx every cycle.
- A req bit that hits its own line in the same cycle that line is served re-arms it. This is a new request, not an overflow.
- overflow <= 1 when (req & pending & ~served) != 0. It clears only on rst or clr.
- FSM states:
  - IDLE: op_valid=0. If pend_nx != 0, load op_code=select(pend_nx & ~served), set op_valid=1, go to OFFER.
  - OFFER: op_code and op_valid are held stable while op_ready=0. On handshake, if (pend_nx & ~served) != 0, load the next op_code and stay in OFFER (back-to-back issue, no bubble). Otherwise op_valid<=0 and go to IDLE.
- select(): lowest set index wins (fixed priority), unless round-robin is compiled in (see Configuration).
- op_valid never deasserts without a handshake, except on rst or clr.

## Timing
- Request latency: req bit high in cycle n gives op_valid=1 with that code in cycle n+1, provided the encoder is idle and the line wins arbitration.
- Throughput: one opcode per cycle while op_ready=1 and work is pending.
- All outputs are registers. There is no combinational path from req or op_ready to any output.
- All-16-request burst with op_ready tied high: codes issue over 16 consecutive cycles, then op_valid=0 in the 17th.

## Configuration
- OP_ENCODER_RR_EN defined:
  - select() searches upward from (rr_ptr+1) mod 16, wrapping 15 to 0.
  - rr_ptr <= op_code on each handshake.
  - rr_ptr resets (rst or clr) to 15, so index 0 has first priority.
- OP_ENCODER_RR_EN undefined: fixed lowest-index priority; rr_ptr is not present.

## Structure
- Package op_encoder_pkg holds:
  - constants N_REQ and CODE_W;
  - the state enum {IDLE, OFFER};
  - the function onehot(code).
- Sub-module prio_enc16: combinational 16-bit masked priority encoder.
  - Inputs: vec[15:0], start[3:0]; start is tied to 0 in fixed mode.
  - Outputs: code[3:0], found.
  - The rotate-search lives here; op_encoder owns the registers and the FSM.

## Test plan
- Reset, then req=16'h0000 for 5 cycles: op_valid=0, pending=0, overflow=0 throughout.
- req=16'h0024 for one cycle, op_ready=1: op_code=2 next cycle, then 5 the following cycle, then op_valid=0; overflow stays 0.
- op_ready=0 with pending 16'h0001, pulse req[0] again: overflow=1 and op_code stays 0 held stable. Then op_ready=1: a single issue of code 0, after which pending=0.
- req=16'hFFFF with op_ready=1: codes issue one per cycle for 16 cycles, with no bubble between them.
  - Fixed mode order: 0,1,…,15.
  - With OP_ENCODER_RR_EN and pending 16'h8003 after code 0 is served: code 1, then 15, then 0 if re-requested.
- Mid-offer clr=1 with op_ready=1: next cycle op_valid=0, pending=0, overflow=0, and that code is not counted as served.
- Handshake on code 3 with req[3]=1 in the same cycle: pending[3]=1 afterwards, code 3 is reissued, and overflow stays 0.
